serial_subtractor: RTL and testbench

//  Bit-serial unsigned/two's-complement subtractor: diff = a - b, computed LSB-first,
//  one bit per clock, through a single 1-bit full-adder cell as a + ~b + 1.
//  It is the inverse-direction companion to the team's full-adder datapath. It serves

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_fa_cell.sv | 17 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the bit-counter width helper.
package serial_subtractor_pkg;

    // 2'd3 is unused and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// Combinational 1-bit full adder, the only arithmetic cell in the serial
// subtractor datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB-first as a + ~b + 1,
// one bit per clock through a single full-adder cell, with a start/done
// handshake and registered results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic             ovf_reg, ovf_next;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_shift;

    // Single adder cell; the subtrahend bit is inverted on its way in and
    // the +1 comes from the carry being preset to 1 on accept.
    fa_cell u_fa (
        .a    (a_sh_reg[0]),
        .b    (~b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (s_bit),
        .cout (c_bit)
    );

    assign res_shift = {s_bit, res_reg[WIDTH-1:1]};

    // Next-state logic for the FSM, datapath shifters and output registers.
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_next    = res_reg;
        carry_next  = carry_reg;
        count_next  = count_reg;
        done_next   = 1'b0;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = 1'b1;
                    count_next = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                res_next   = res_shift;
                carry_next = c_bit;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_BIT) begin
                    // Last bit: carry_reg is the carry into the MSB and
                    // c_bit the carry out of it, so results are final now.
                    state_next  = ST_DONE;
                    count_next  = '0;
                    done_next   = 1'b1;
                    diff_next   = res_shift;
                    borrow_next = ~c_bit;
                    ovf_next    = carry_reg ^ c_bit;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_reg    <= res_next;
            carry_reg  <= carry_next;
            count_reg  <= count_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;
    assign overflow   = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed operations
// with a scoreboard of expected results popped on every done pulse.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             br;
        logic             ov;
    } exp_t;

    exp_t sb[$];

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int n_done  = 0;
    int t_done0 = 0;
    int t_done1 = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain modular subtraction and sign rules.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.br = (av < bv);
        e.ov = (av[WIDTH-1] != bv[WIDTH-1]) && (e.d[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            t_done0 = t_done1;
            t_done1 = cyc;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("done: diff=%0d borrow=%0b ovf=%0b (exp %0d %0b %0b)",
                         diff, borrow_out, overflow, e.d, e.br, e.ov);
                check("diff", 32'(diff), 32'(e.d));
                check("borrow", 32'(borrow_out), 32'(e.br));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; optionally re-pulses start at offset inject
    // (edges after the accept edge) to show it is ignored.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int inject);
        int lat;
        lat   = -1;
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back(model(av, bv));
        step();                     // accept edge T
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == inject) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd1;
            end else if (k == inject + 1) begin
                start = 1'b0;
            end
            step();
            if (inject > 0 && k <= WIDTH) check("busy_run", 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check("done_latency", 32'(lat), 32'(WIDTH));
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic operations and sign/borrow corners.
        do_op(8'd200, 8'd55, 0);
        do_op(8'd5, 8'd10, 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h7F, 8'hFF, 0);
        do_op(8'd42, 8'd42, 0);
        do_op(8'd77, 8'd0, 0);

        // Start re-pulsed during RUN must be ignored.
        base = n_done;
        do_op(8'd9, 8'd3, 3);
        repeat (12) step();
        check("ignored_start_dones", 32'(n_done - base), 32'd1);
        check("sb_empty_after_ignore", 32'(sb.size()), 32'd0);

        // Reset mid-RUN aborts without a done pulse.
        base  = n_done;
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        repeat (12) step();
        check("abort_no_done", 32'(n_done - base), 32'd0);
        do_op(8'd130, 8'd33, 0);

        // Start held high: back-to-back operations.
        base  = n_done;
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        sb.push_back(model(8'd1, 8'd1));
        step();
        a = 8'd255;
        b = 8'd0;
        sb.push_back(model(8'd255, 8'd0));
        for (int k = 0; k < 40 && (n_done - base) < 2; k++) step();
        start = 1'b0;
        check("b2b_dones", 32'(n_done - base), 32'd2);
        check("b2b_spacing", 32'(t_done1 - t_done0), 32'(WIDTH + 2));
        repeat (14) step();
        check("b2b_no_extra", 32'(n_done - base), 32'd2);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
